// File: rtl/beam_pkg.sv
// beam_pkg: shared defaults and types for the beam-scan controller slice.
//   - Default widths/sizes for the sample buffers, lag scan and SAD accumulator.
//   - beam_state_e: controller state encoding, also exported on state_o.
//   - ACC_INIT: all-ones seed for the running minimum (truncated at use).
//   - lag_to_led(): one-hot bucket decode used when BEAM_LED_DECODE_EN is defined.
package beam_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int WINDOW_DEF     = 30;
  localparam int NUM_LAGS_DEF   = 60;
  localparam int ACC_WIDTH_DEF  = 22;
  localparam int ADDR_WIDTH_DEF = 7;
  localparam int LAG_WIDTH      = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_SCAN    = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DONE    = 3'd4
  } beam_state_e;

  // Wider than any accumulator; users cast it down, which keeps it all-ones.
  localparam logic [63:0] ACC_INIT = '1;

  // Map a lag onto one of eight equal buckets and return it one-hot.
  function automatic logic [7:0] lag_to_led(input logic [LAG_WIDTH-1:0] lag,
                                            input int num_lags);
    int bucket;
    bucket = (int'(lag) * 8) / num_lags;
    if (bucket > 7) bucket = 7;
    return 8'(1) << bucket;
  endfunction

endpackage

// File: rtl/beam_scan_controller_if.sv
// beam_buf_if: port bundle between the controller and the external left/right
// sample buffers.
//   master (controller): drives write enables, shared write address, read
//                        strobe and both read addresses; receives read data.
//   slave  (buffers):    the mirror image.
// Read data is expected one cycle after rd_en, from the addresses presented
// in the rd_en cycle. Writes take effect on the clock edge ending the cycle
// in which the enable is high.
interface beam_buf_if
  import beam_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  left_wr_en;
  logic                  right_wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] left_rd_addr;
  logic [ADDR_WIDTH-1:0] right_rd_addr;
  logic [DATA_WIDTH-1:0] left_rd_data;
  logic [DATA_WIDTH-1:0] right_rd_data;

  modport master (
    output left_wr_en, right_wr_en, wr_addr, rd_en, left_rd_addr, right_rd_addr,
    input  left_rd_data, right_rd_data
  );

  modport slave (
    input  left_wr_en, right_wr_en, wr_addr, rd_en, left_rd_addr, right_rd_addr,
    output left_rd_data, right_rd_data
  );

endinterface

// File: rtl/beam_scan_controller_sad_accumulator.sv
// sad_accumulator: absolute-difference accumulate and running-minimum search.
//   clk, reset     : clock, asynchronous active-high reset
//   clear_i        : reseed the minimum to all-ones (new job starting)
//   valid_i        : left_i/right_i carry buffer read data this cycle
//   first_i/last_i : this sample opens / closes the current lag's window
//   lag_i          : lag index the sample belongs to
//   left_i/right_i : signed samples
//   best_lag_o     : lag of the smallest SAD so far
//   best_sad_o     : smallest SAD so far
// The best_* outputs show the next-state values, so a compare landing on a
// clock edge is visible to a register loading on that same edge.
module sad_accumulator
  import beam_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  valid_i,
  input  logic                  first_i,
  input  logic                  last_i,
  input  logic [LAG_WIDTH-1:0]  lag_i,
  input  logic [DATA_WIDTH-1:0] left_i,
  input  logic [DATA_WIDTH-1:0] right_i,
  output logic [LAG_WIDTH-1:0]  best_lag_o,
  output logic [ACC_WIDTH-1:0]  best_sad_o
);

  logic signed [DATA_WIDTH:0] diff;
  logic        [DATA_WIDTH:0] mag;
  logic        [ACC_WIDTH-1:0] abs_ext;

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] min_q, min_d;
  logic [LAG_WIDTH-1:0] best_lag_q, best_lag_d;
  logic [LAG_WIDTH-1:0] cmp_lag_q, cmp_lag_d;
  logic                 cmp_pend_q, cmp_pend_d;

  // One extra bit so the full signed range of the difference is exact.
  always_comb begin
    diff    = $signed({left_i[DATA_WIDTH-1], left_i}) -
              $signed({right_i[DATA_WIDTH-1], right_i});
    mag     = diff[DATA_WIDTH] ? DATA_WIDTH'(1'b0) - diff : diff;
    abs_ext = ACC_WIDTH'(mag);
  end

  always_comb begin
    acc_d      = acc_q;
    min_d      = min_q;
    best_lag_d = best_lag_q;
    cmp_lag_d  = cmp_lag_q;
    cmp_pend_d = 1'b0;

    if (valid_i) begin
      acc_d = first_i ? abs_ext : acc_q + abs_ext;
    end

    // The compare runs one cycle after a lag's last sample is folded in.
    if (valid_i && last_i) begin
      cmp_pend_d = 1'b1;
      cmp_lag_d  = lag_i;
    end

    // Strict less-than: on a tie the earlier lag keeps the win.
    if (cmp_pend_q && (acc_q < min_q)) begin
      min_d      = acc_q;
      best_lag_d = cmp_lag_q;
    end

    if (clear_i) begin
      min_d      = ACC_WIDTH'(ACC_INIT);
      best_lag_d = '0;
      cmp_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= '0;
      min_q      <= ACC_WIDTH'(ACC_INIT);
      best_lag_q <= '0;
      cmp_lag_q  <= '0;
      cmp_pend_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      min_q      <= min_d;
      best_lag_q <= best_lag_d;
      cmp_lag_q  <= cmp_lag_d;
      cmp_pend_q <= cmp_pend_d;
    end
  end

  assign best_lag_o = best_lag_d;
  assign best_sad_o = min_d;

endmodule

// File: rtl/beam_scan_controller.sv
// beam_scan_controller: capture + lag-scan sequencer for the two-microphone
// beam-forming SAD datapath.
//   clk, reset       : clock, asynchronous active-high reset (aborts any job)
//   start_i          : begin capture+scan; only looked at in IDLE or DONE
//   sample_valid_i   : streaming left/right sample present this cycle
//   buf_if (master)  : buffer writes during capture, reads during scan
//   busy_o           : high through CAPTURE, SCAN and FLUSH
//   done_o           : one-cycle pulse when the result is latched
//   result_valid_o   : best_lag_o/best_sad_o hold a finished result
//   best_lag_o       : winning lag 0..NUM_LAGS-1
//   best_sad_o       : SAD of the winning lag
//   state_o          : current controller state
//   led_pattern_o    : one-hot lag bucket (only with BEAM_LED_DECODE_EN)
// Handshake: start_i is accepted for one cycle in IDLE/DONE and ignored while
// busy_o is high; the job then runs to completion and signals with a single
// done_o pulse, after which result_valid_o stays high until the next accepted
// start. Buffer reads return data the cycle after rd_en.
// Optional feature macro: BEAM_LED_DECODE_EN.
module beam_scan_controller
  import beam_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int WINDOW     = WINDOW_DEF,
  parameter int NUM_LAGS   = NUM_LAGS_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic                 sample_valid_i,
  beam_buf_if.master           buf_if,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 result_valid_o,
  output logic [LAG_WIDTH-1:0] best_lag_o,
  output logic [ACC_WIDTH-1:0] best_sad_o,
  output beam_state_e          state_o
`ifdef BEAM_LED_DECODE_EN
  ,
  output logic [7:0]           led_pattern_o
`endif
);

  localparam int J_W = $clog2(WINDOW);

  localparam logic [ADDR_WIDTH-1:0] N_LAST  = ADDR_WIDTH'(3 * WINDOW - 1);
  localparam logic [ADDR_WIDTH-1:0] LEFT_LO = ADDR_WIDTH'(WINDOW);
  localparam logic [ADDR_WIDTH-1:0] LEFT_HI = ADDR_WIDTH'(2 * WINDOW);
  localparam logic [J_W-1:0]        J_LAST  = J_W'(WINDOW - 1);
  localparam logic [LAG_WIDTH-1:0]  L_LAST  = LAG_WIDTH'(NUM_LAGS - 1);

  beam_state_e           state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [J_W-1:0]        j_q;
  logic [LAG_WIDTH-1:0]  lag_q;
  logic                  flush_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  rv_q;
  logic [LAG_WIDTH-1:0]  best_lag_q;
  logic [ACC_WIDTH-1:0]  best_sad_q;

  // Read-side tags travel one stage to line up with the returned data.
  logic                  pipe_vld_q;
  logic                  pipe_first_q;
  logic                  pipe_last_q;
  logic [LAG_WIDTH-1:0]  pipe_lag_q;

  logic                  capture;
  logic                  scan;
  logic                  start_accept;
  logic [LAG_WIDTH-1:0]  sad_best_lag;
  logic [ACC_WIDTH-1:0]  sad_best_sad;

`ifdef BEAM_LED_DECODE_EN
  logic [7:0]            led_q;
`endif

  assign capture      = (state_q == ST_CAPTURE);
  assign scan         = (state_q == ST_SCAN);
  assign start_accept = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Write strobes follow sample_valid in the same cycle so the buffer latches
  // the streaming sample presented alongside it.
  assign buf_if.right_wr_en   = capture && sample_valid_i;
  assign buf_if.left_wr_en    = capture && sample_valid_i &&
                                (cnt_q >= LEFT_LO) && (cnt_q < LEFT_HI);
  assign buf_if.wr_addr       = capture ? cnt_q : '0;
  assign buf_if.rd_en         = scan;
  assign buf_if.left_rd_addr  = scan ? LEFT_LO + ADDR_WIDTH'(j_q) : '0;
  assign buf_if.right_rd_addr = scan ? ADDR_WIDTH'(j_q) + ADDR_WIDTH'(lag_q) : '0;

  sad_accumulator #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_sad (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (start_accept),
    .valid_i    (pipe_vld_q),
    .first_i    (pipe_first_q),
    .last_i     (pipe_last_q),
    .lag_i      (pipe_lag_q),
    .left_i     (buf_if.left_rd_data),
    .right_i    (buf_if.right_rd_data),
    .best_lag_o (sad_best_lag),
    .best_sad_o (sad_best_sad)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      j_q          <= '0;
      lag_q        <= '0;
      flush_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rv_q         <= 1'b0;
      best_lag_q   <= '0;
      best_sad_q   <= '0;
      pipe_vld_q   <= 1'b0;
      pipe_first_q <= 1'b0;
      pipe_last_q  <= 1'b0;
      pipe_lag_q   <= '0;
`ifdef BEAM_LED_DECODE_EN
      led_q        <= 8'h01;
`endif
    end else begin
      done_q       <= 1'b0;
      pipe_vld_q   <= scan;
      pipe_first_q <= (j_q == '0);
      pipe_last_q  <= (j_q == J_LAST);
      pipe_lag_q   <= lag_q;

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_q <= ST_CAPTURE;
            busy_q  <= 1'b1;
            rv_q    <= 1'b0;
            cnt_q   <= '0;
          end
        end

        ST_CAPTURE: begin
          if (sample_valid_i) begin
            if (cnt_q == N_LAST) begin
              state_q <= ST_SCAN;
              cnt_q   <= '0;
              j_q     <= '0;
              lag_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        ST_SCAN: begin
          if (j_q == J_LAST) begin
            j_q <= '0;
            if (lag_q == L_LAST) begin
              state_q <= ST_FLUSH;
              lag_q   <= '0;
              flush_q <= 1'b0;
            end else begin
              lag_q <= lag_q + 1'b1;
            end
          end else begin
            j_q <= j_q + 1'b1;
          end
        end

        // Two cycles: the last lag's data is accumulated, then compared.
        // The result is taken from the accumulator's next-state view so the
        // final compare is included.
        ST_FLUSH: begin
          if (flush_q) begin
            flush_q    <= 1'b0;
            state_q    <= ST_DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            rv_q       <= 1'b1;
            best_lag_q <= sad_best_lag;
            best_sad_q <= sad_best_sad;
`ifdef BEAM_LED_DECODE_EN
            led_q      <= lag_to_led(sad_best_lag, NUM_LAGS);
`endif
          end else begin
            flush_q <= 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign result_valid_o = rv_q;
  assign best_lag_o     = best_lag_q;
  assign best_sad_o     = best_sad_q;
  assign state_o        = state_q;
`ifdef BEAM_LED_DECODE_EN
  assign led_pattern_o  = led_q;
`endif

endmodule

// File: tb/tb_beam_scan_controller.sv
module tb_beam_scan_controller;
  import beam_pkg::*;

  localparam int DW  = 16;
  localparam int WIN = 30;
  localparam int NL  = 60;
  localparam int AW  = 22;
  localparam int ADW = 7;
  localparam int NS  = 3 * WIN;
  localparam int LAT = NL * WIN + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          start_i = 1'b0;
  logic          sample_valid_i = 1'b0;
  logic [DW-1:0] left_in = '0;
  logic [DW-1:0] right_in = '0;
  logic          busy_o, done_o, result_valid_o;
  logic [5:0]    best_lag_o;
  logic [AW-1:0] best_sad_o;
  beam_state_e   state_o;
`ifdef BEAM_LED_DECODE_EN
  logic [7:0]    led_pattern_o;
`endif

  beam_buf_if #(.ADDR_WIDTH(ADW), .DATA_WIDTH(DW)) buf_if ();

  beam_scan_controller #(
    .DATA_WIDTH(DW), .WINDOW(WIN), .NUM_LAGS(NL), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start_i),
    .sample_valid_i (sample_valid_i),
    .buf_if         (buf_if),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .result_valid_o (result_valid_o),
    .best_lag_o     (best_lag_o),
    .best_sad_o     (best_sad_o),
    .state_o        (state_o)
`ifdef BEAM_LED_DECODE_EN
    ,
    .led_pattern_o  (led_pattern_o)
`endif
  );

  // ---------------- external sample buffers ----------------
  logic [DW-1:0] left_mem [0:127];
  logic [DW-1:0] right_mem[0:127];

  initial begin
    for (int i = 0; i < 128; i++) begin
      left_mem[i]  = '0;
      right_mem[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (buf_if.right_wr_en) right_mem[buf_if.wr_addr] <= right_in;
    if (buf_if.left_wr_en)  left_mem[buf_if.wr_addr]  <= left_in;
    if (buf_if.rd_en) begin
      buf_if.left_rd_data  <= left_mem[buf_if.left_rd_addr];
      buf_if.right_rd_data <= right_mem[buf_if.right_rd_addr];
    end
  end

  // ---------------- monitor (logs only) ----------------
  logic [ADW-1:0] wr_log[$];
  logic [ADW-1:0] lwr_log[$];
  logic [ADW-1:0] exp_q[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    if (buf_if.right_wr_en) wr_log.push_back(buf_if.wr_addr);
    if (buf_if.left_wr_en)  lwr_log.push_back(buf_if.wr_addr);
    if (done_o) done_cnt++;
  end

  // ---------------- stimulus data + reference model ----------------
  int l_stream[NS];
  int r_stream[NS];
  int tests_run = 0;
  int tests_failed = 0;
  int last_cyc = 0;

  int obs_timeout, obs_lat, obs_lag, obs_sad, obs_rv, obs_busy, obs_done_next, obs_led;

  // Best lag = argmin over lags of sum |left window - shifted right window|,
  // earliest lag on ties.
  function automatic void model_best(output int lag, output int sad);
    int s, d;
    sad = 32'h7fffffff;
    lag = 0;
    for (int l = 0; l < NL; l++) begin
      s = 0;
      for (int j = 0; j < WIN; j++) begin
        d = l_stream[WIN + j] - r_stream[j + l];
        s += (d < 0) ? -d : d;
      end
      if (s < sad) begin
        sad = s;
        lag = l;
      end
    end
  endfunction

  function automatic int model_led(input int lag);
    return 1 << ((lag * 8) / NL);
  endfunction

  task automatic fill_random(input int lo, input int hi);
    for (int n = 0; n < NS; n++) begin
      l_stream[n] = int'($urandom_range(0, hi - lo)) + lo;
      r_stream[n] = int'($urandom_range(0, hi - lo)) + lo;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
  endtask

  task automatic drive_samples(input bit gaps);
    for (int n = 0; n < NS; n++) begin
      sample_valid_i = 1'b1;
      left_in  = DW'(l_stream[n]);
      right_in = DW'(r_stream[n]);
      last_cyc = cyc;
      @(posedge clk); #1;
      if (gaps) begin
        sample_valid_i = 1'b0;
        left_in  = 16'($urandom);
        right_in = 16'($urandom);
        @(posedge clk); #1;
      end
    end
    sample_valid_i = 1'b0;
  endtask

  // Waits (bounded) for done and records what the outputs show.
  task automatic wait_done();
    int k = 0;
    obs_timeout = 0;
    while (done_o !== 1'b1 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    if (done_o !== 1'b1) obs_timeout = 1;
    obs_lat  = cyc - last_cyc;
    obs_lag  = int'(best_lag_o);
    obs_sad  = int'(best_sad_o);
    obs_rv   = int'(result_valid_o);
    obs_busy = int'(busy_o);
`ifdef BEAM_LED_DECODE_EN
    obs_led  = int'(led_pattern_o);
`else
    obs_led  = 0;
`endif
    @(negedge clk);
    obs_done_next = int'(done_o);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({busy_o, done_o, result_valid_o, buf_if.rd_en, buf_if.right_wr_en, buf_if.left_wr_en} !== 6'b0) begin
      tests_failed++; $display("FAIL reset_ctrl got %b required 000000",
        {busy_o, done_o, result_valid_o, buf_if.rd_en, buf_if.right_wr_en, buf_if.left_wr_en});
    end
    tests_run++;
    if (best_lag_o !== 6'd0 || best_sad_o !== '0) begin
      tests_failed++; $display("FAIL reset_result got lag=%0d sad=%0d required 0/0", best_lag_o, best_sad_o);
    end
    tests_run++;
    if (state_o !== ST_IDLE) begin
      tests_failed++; $display("FAIL reset_state got %0d required %0d", state_o, ST_IDLE);
    end
`ifdef BEAM_LED_DECODE_EN
    tests_run++;
    if (led_pattern_o !== 8'h01) begin
      tests_failed++; $display("FAIL reset_led got %h required 01", led_pattern_o);
    end
`endif
    @(posedge clk); #1 reset = 1'b0;
    // sample_valid with no start must not write.
    wr_log.delete();
    sample_valid_i = 1'b1;
    repeat (5) @(posedge clk);
    #1 sample_valid_i = 1'b0;
    tests_run++;
    if (wr_log.size() != 0 || state_o !== ST_IDLE) begin
      tests_failed++; $display("FAIL idle_ignore got writes=%0d state=%0d required 0/%0d", wr_log.size(), state_o, ST_IDLE);
    end
  endtask

  task automatic test_zero();
    for (int n = 0; n < NS; n++) begin l_stream[n] = 0; r_stream[n] = 0; end
    wr_log.delete(); lwr_log.delete();
    pulse_start();
    drive_samples(1'b0);
    wait_done();
    tests_run++;
    if (obs_timeout != 0) begin tests_failed++; $display("FAIL zero_timeout got no done required done"); end
    tests_run++;
    if (obs_lat != LAT) begin tests_failed++; $display("FAIL zero_latency got %0d required %0d", obs_lat, LAT); end
    tests_run++;
    if (obs_lag != 0 || obs_sad != 0) begin
      tests_failed++; $display("FAIL zero_result got lag=%0d sad=%0d required 0/0", obs_lag, obs_sad);
    end
    tests_run++;
    if (obs_rv != 1 || obs_busy != 0 || obs_done_next != 0) begin
      tests_failed++; $display("FAIL zero_flags got rv=%0d busy=%0d done_next=%0d required 1/0/0", obs_rv, obs_busy, obs_done_next);
    end
    tests_run++;
    if (wr_log.size() != NS || lwr_log.size() != WIN) begin
      tests_failed++; $display("FAIL zero_writes got %0d/%0d required %0d/%0d", wr_log.size(), lwr_log.size(), NS, WIN);
    end
  endtask

  task automatic test_lag17();
    int el, es;
    for (int n = 0; n < NS; n++) begin
      r_stream[n] = 100 * n;
      l_stream[n] = (n >= WIN && n < 2 * WIN) ? 100 * (n - WIN + 17) : int'($urandom_range(0, 2000)) - 1000;
    end
    model_best(el, es);
    pulse_start();
    drive_samples(1'b0);
    wait_done();
    tests_run++;
    if (obs_timeout != 0 || obs_lat != LAT) begin
      tests_failed++; $display("FAIL lag17_latency got %0d (timeout=%0d) required %0d", obs_lat, obs_timeout, LAT);
    end
    tests_run++;
    if (obs_lag != 17 || obs_sad != 0 || obs_lag != el || obs_sad != es) begin
      tests_failed++; $display("FAIL lag17_result got lag=%0d sad=%0d required 17/0", obs_lag, obs_sad);
    end
`ifdef BEAM_LED_DECODE_EN
    tests_run++;
    if (obs_led != 8'h04) begin tests_failed++; $display("FAIL lag17_led got %h required 04", obs_led); end
`endif
  endtask

  task automatic test_extreme();
    for (int n = 0; n < NS; n++) begin l_stream[n] = 32767; r_stream[n] = -32768; end
    pulse_start();
    drive_samples(1'b0);
    wait_done();
    tests_run++;
    if (obs_timeout != 0 || obs_lag != 0 || obs_sad != 1966050) begin
      tests_failed++; $display("FAIL extreme_result got lag=%0d sad=%0d timeout=%0d required 0/1966050/0", obs_lag, obs_sad, obs_timeout);
    end
`ifdef BEAM_LED_DECODE_EN
    tests_run++;
    if (obs_led != 8'h01) begin tests_failed++; $display("FAIL extreme_led got %h required 01", obs_led); end
`endif
  endtask

  task automatic test_gaps();
    int el, es, lag0, sad0, bad;
    fill_random(-32768, 32767);
    model_best(el, es);
    pulse_start();
    drive_samples(1'b0);
    wait_done();
    lag0 = obs_lag; sad0 = obs_sad;
    wr_log.delete(); lwr_log.delete();
    pulse_start();
    drive_samples(1'b1);
    wait_done();
    bad = 0;
    exp_q.delete();
    for (int n = 0; n < NS; n++) exp_q.push_back(ADW'(n));
    if (wr_log.size() != exp_q.size()) bad++;
    else foreach (exp_q[i]) if (wr_log[i] !== exp_q[i]) bad++;
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL gaps_wr_order got %0d writes %0d bad required %0d in order", wr_log.size(), bad, NS); end
    bad = 0;
    exp_q.delete();
    for (int n = WIN; n < 2 * WIN; n++) exp_q.push_back(ADW'(n));
    if (lwr_log.size() != exp_q.size()) bad++;
    else foreach (exp_q[i]) if (lwr_log[i] !== exp_q[i]) bad++;
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL gaps_left_wr got %0d writes %0d bad required 30..59", lwr_log.size(), bad); end
    tests_run++;
    if (obs_timeout != 0 || obs_lat != LAT) begin
      tests_failed++; $display("FAIL gaps_latency got %0d required %0d", obs_lat, LAT);
    end
    tests_run++;
    if (obs_lag != el || obs_sad != es || lag0 != el || sad0 != es) begin
      tests_failed++; $display("FAIL gaps_result got %0d/%0d and %0d/%0d required %0d/%0d", lag0, sad0, obs_lag, obs_sad, el, es);
    end
  endtask

  task automatic test_random();
    int el, es;
    for (int it = 0; it < 3; it++) begin
      if (it == 2) fill_random(0, 3);          // small range: many ties
      else fill_random(-32768, 32767);
      model_best(el, es);
      wr_log.delete();
      pulse_start();
      drive_samples(1'b0);
      // sample_valid noise during the scan must not write anything
      repeat (60) begin
        @(posedge clk); #1;
        sample_valid_i = 1'($urandom_range(0, 1));
        left_in = 16'($urandom);
      end
      sample_valid_i = 1'b0;
      wait_done();
      tests_run++;
      if (obs_timeout != 0 || obs_lag != el || obs_sad != es) begin
        tests_failed++; $display("FAIL random%0d_result got lag=%0d sad=%0d required %0d/%0d", it, obs_lag, obs_sad, el, es);
      end
      tests_run++;
      if (wr_log.size() != NS) begin tests_failed++; $display("FAIL random%0d_writes got %0d required %0d", it, wr_log.size(), NS); end
`ifdef BEAM_LED_DECODE_EN
      tests_run++;
      if (obs_led != model_led(el)) begin
        tests_failed++; $display("FAIL random%0d_led got %h required %h", it, obs_led, model_led(el));
      end
`endif
    end
  endtask

  task automatic test_start_during_scan();
    int el, es, d0;
    fill_random(-2000, 2000);
    model_best(el, es);
    d0 = done_cnt;
    pulse_start();
    drive_samples(1'b0);
    repeat (300) @(posedge clk);
    #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    wait_done();
    repeat (20) @(negedge clk);
    tests_run++;
    if (done_cnt - d0 != 1 || state_o !== ST_DONE) begin
      tests_failed++; $display("FAIL busy_start got dones=%0d state=%0d required 1/%0d", done_cnt - d0, state_o, ST_DONE);
    end
    tests_run++;
    if (obs_lat != LAT || obs_lag != el || obs_sad != es) begin
      tests_failed++; $display("FAIL busy_start_result got lat=%0d lag=%0d sad=%0d required %0d/%0d/%0d", obs_lat, obs_lag, obs_sad, LAT, el, es);
    end
  endtask

  task automatic test_reset_mid_scan();
    int el, es, d0;
    fill_random(-32768, 32767);
    pulse_start();
    drive_samples(1'b0);
    repeat (25 * WIN + 5) @(posedge clk);
    #1;
    tests_run++;
    if (state_o !== ST_SCAN || busy_o !== 1'b1) begin
      tests_failed++; $display("FAIL mid_scan_state got %0d busy=%b required %0d/1", state_o, busy_o, ST_SCAN);
    end
    d0 = done_cnt;
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (busy_o !== 1'b0 || result_valid_o !== 1'b0 || done_o !== 1'b0 || state_o !== ST_IDLE || buf_if.rd_en !== 1'b0) begin
      tests_failed++; $display("FAIL abort_outputs got busy=%b rv=%b done=%b state=%0d rd=%b required 0/0/0/0/0",
        busy_o, result_valid_o, done_o, state_o, buf_if.rd_en);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (40) @(negedge clk);
    tests_run++;
    if (done_cnt != d0 || result_valid_o !== 1'b0 || state_o !== ST_IDLE) begin
      tests_failed++; $display("FAIL abort_no_done got dones=%0d rv=%b state=%0d required 0/0/%0d", done_cnt - d0, result_valid_o, state_o, ST_IDLE);
    end
    fill_random(-500, 500);
    model_best(el, es);
    pulse_start();
    drive_samples(1'b0);
    wait_done();
    tests_run++;
    if (obs_timeout != 0 || obs_lat != LAT || obs_lag != el || obs_sad != es || obs_rv != 1) begin
      tests_failed++; $display("FAIL after_abort got lat=%0d lag=%0d sad=%0d rv=%0d required %0d/%0d/%0d/1", obs_lat, obs_lag, obs_sad, obs_rv, LAT, el, es);
    end
  endtask

  task automatic test_restart_from_done();
    int el, es;
    tests_run++;
    if (state_o !== ST_DONE || result_valid_o !== 1'b1) begin
      tests_failed++; $display("FAIL restart_pre got state=%0d rv=%b required %0d/1", state_o, result_valid_o, ST_DONE);
    end
    fill_random(-10000, 10000);
    model_best(el, es);
    wr_log.delete();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    tests_run++;
    if (result_valid_o !== 1'b0 || busy_o !== 1'b1 || state_o !== ST_CAPTURE) begin
      tests_failed++; $display("FAIL restart_entry got rv=%b busy=%b state=%0d required 0/1/%0d", result_valid_o, busy_o, state_o, ST_CAPTURE);
    end
    drive_samples(1'b0);
    wait_done();
    tests_run++;
    if (wr_log.size() != NS || wr_log[0] !== 7'd0) begin
      tests_failed++; $display("FAIL restart_first_addr got size=%0d first=%0d required %0d/0", wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : 7'd127, NS);
    end
    tests_run++;
    if (obs_timeout != 0 || obs_lag != el || obs_sad != es) begin
      tests_failed++; $display("FAIL restart_result got lag=%0d sad=%0d required %0d/%0d", obs_lag, obs_sad, el, es);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_zero();
    test_lag17();
    test_extreme();
    test_gaps();
    test_random();
    test_start_during_scan();
    test_reset_mid_scan();
    test_restart_from_done();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
